// File: rtl/stream_splitter_with_flow_control.sv
// stream_splitter_with_flow_control
// Splits each packed input word {b, a} into two independent valid/ready
// branches. Each branch has its own 2-entry FIFO, so one consumer can run up
// to two words ahead of the other. in_rdy is a function of registered FIFO
// counts only, so there is no combinational path from a_rdy/b_rdy to in_rdy.
// Optional build macro: STREAM_SPLITTER_COUNTERS_EN adds transfer counters
// (in_cnt, a_cnt, b_cnt) and a registered branch skew output.
module stream_splitter_with_flow_control #(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [2*width-1:0] in_data,
  output logic               a_vld,
  input  logic               a_rdy,
  output logic [width-1:0]   a_data,
  output logic               b_vld,
  input  logic               b_rdy,
  output logic [width-1:0]   b_data
`ifdef STREAM_SPLITTER_COUNTERS_EN
  ,
  output logic [15:0]        in_cnt,
  output logic [15:0]        a_cnt,
  output logic [15:0]        b_cnt,
  output logic [1:0]         skew
`endif
);

  logic [width-1:0] mem_a [2];
  logic [width-1:0] mem_b [2];
  logic             wr_a, rd_a, wr_b, rd_b;
  logic [1:0]       cnt_a, cnt_b;
  logic [1:0]       cnt_a_nxt, cnt_b_nxt;
  logic             push, pop_a, pop_b;

  // Handshakes and head outputs, all derived from registered state.
  always_comb begin
    in_rdy = rst & (cnt_a != 2'd2) & (cnt_b != 2'd2);
    a_vld  = (cnt_a != 2'd0);
    b_vld  = (cnt_b != 2'd0);
    a_data = mem_a[rd_a];
    b_data = mem_b[rd_b];
    push   = in_vld & in_rdy;
    pop_a  = a_vld & a_rdy;
    pop_b  = b_vld & b_rdy;
  end

  // Next occupancy per branch; push and pop together leave the count as is.
  always_comb begin
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    case ({push, pop_a})
      2'b10:   cnt_a_nxt = cnt_a + 2'd1;
      2'b01:   cnt_a_nxt = cnt_a - 2'd1;
      default: cnt_a_nxt = cnt_a;
    endcase
    case ({push, pop_b})
      2'b10:   cnt_b_nxt = cnt_b + 2'd1;
      2'b01:   cnt_b_nxt = cnt_b - 2'd1;
      default: cnt_b_nxt = cnt_b;
    endcase
  end

  // FIFO storage, pointers and counts; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      wr_a     <= 1'b0;
      rd_a     <= 1'b0;
      wr_b     <= 1'b0;
      rd_b     <= 1'b0;
      cnt_a    <= 2'd0;
      cnt_b    <= 2'd0;
    end else begin
      if (push) begin
        mem_a[wr_a] <= in_data[width-1:0];
        mem_b[wr_b] <= in_data[2*width-1:width];
        wr_a        <= ~wr_a;
        wr_b        <= ~wr_b;
      end
      if (pop_a) rd_a <= ~rd_a;
      if (pop_b) rd_b <= ~rd_b;
      cnt_a <= cnt_a_nxt;
      cnt_b <= cnt_b_nxt;
    end
  end

`ifdef STREAM_SPLITTER_COUNTERS_EN
  logic [1:0] skew_nxt;

  // Magnitude of the occupancy difference the branches will have next cycle.
  always_comb begin
    skew_nxt = (cnt_a_nxt >= cnt_b_nxt) ? (cnt_a_nxt - cnt_b_nxt)
                                        : (cnt_b_nxt - cnt_a_nxt);
  end

  // Free-running wrap-around transfer counters and registered skew.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_cnt <= 16'd0;
      a_cnt  <= 16'd0;
      b_cnt  <= 16'd0;
      skew   <= 2'd0;
    end else begin
      if (push)  in_cnt <= in_cnt + 16'd1;
      if (pop_a) a_cnt  <= a_cnt + 16'd1;
      if (pop_b) b_cnt  <= b_cnt + 16'd1;
      skew <= skew_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_stream_splitter_with_flow_control.sv
// Testbench for stream_splitter_with_flow_control (width = 8).
// Expected halves are queued when an input transfer is driven; observed
// halves are queued when a branch transfer happens; each test compares them.
module tb_stream_splitter_with_flow_control;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_vld;
  logic           in_rdy;
  logic [2*W-1:0] in_data;
  logic           a_vld, a_rdy, b_vld, b_rdy;
  logic [W-1:0]   a_data, b_data;
`ifdef STREAM_SPLITTER_COUNTERS_EN
  logic [15:0]    in_cnt, a_cnt, b_cnt;
  logic [1:0]     skew;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a[$], exp_b[$], got_a[$], got_b[$];

  stream_splitter_with_flow_control #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data)
`ifdef STREAM_SPLITTER_COUNTERS_EN
    , .in_cnt(in_cnt), .a_cnt(a_cnt), .b_cnt(b_cnt), .skew(skew)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Records the handshakes of the current cycle, then advances one clock.
  task automatic tick(output bit acc);
    acc = in_vld && in_rdy;
    if (acc) begin
      exp_a.push_back(in_data[W-1:0]);
      exp_b.push_back(in_data[2*W-1:W]);
    end
    if (a_vld && a_rdy) got_a.push_back(a_data);
    if (b_vld && b_rdy) got_b.push_back(b_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b0; in_vld = 1'b0; in_data = '0; a_rdy = 1'b0; b_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_rdy !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_rdy: got %b want 0", in_rdy);
      end
      tick(acc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL release_in_rdy: got %b want 1", in_rdy);
    end
    checks++;
    if ({a_vld, b_vld, a_data, b_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a_vld=%b b_vld=%b a_data=%h b_data=%h want all 0",
               a_vld, b_vld, a_data, b_data);
    end
    tick(acc);
    checks++;
    if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_vld: got a=%b b=%b want 0 0", a_vld, b_vld);
    end
  endtask

  task automatic test_single_word();
    bit acc;
    a_rdy = 1'b1; b_rdy = 1'b1;
    in_vld = 1'b1; in_data = 16'hB73C;
    tick(acc);
    in_vld = 1'b0;
    checks++;
    if (!acc || a_vld !== 1'b1 || a_data !== 8'h3C || b_vld !== 1'b1 || b_data !== 8'hB7) begin
      errors++;
      $display("FAIL single_word: got acc=%b a=%b/%h b=%b/%h want 1 1/3c 1/b7",
               acc, a_vld, a_data, b_vld, b_data);
    end
    tick(acc);
    checks++;
    if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_word_once: got a_vld=%b b_vld=%b want 0 0", a_vld, b_vld);
    end
    checks++;
    if (got_a.size() != 1 || got_b.size() != 1 || exp_a.size() != 1) begin
      errors++;
      $display("FAIL single_word_count: got a=%0d b=%0d want 1 1", got_a.size(), got_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_a: got %h want %h", g, e); end
    end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_b: got %h want %h", g, e); end
    end
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic test_back_to_back();
    bit acc;
    a_rdy = 1'b1; b_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1;
      in_data = {8'(i + 1), 8'(i)};
      checks++;
      if (in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_rdy word %0d: got %b want 1", i, in_rdy);
      end
      tick(acc);
    end
    in_vld = 1'b0;
    for (int i = 0; i < 4; i++) tick(acc);
    checks++;
    if (got_a.size() != 8 || got_b.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got a=%0d b=%0d want 8 8", got_a.size(), got_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_a: got %h want %h", g, e); end
    end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_b: got %h want %h", g, e); end
    end
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic test_b_stall();
    bit acc;
    logic [2*W-1:0] w [3];
    w[0] = 16'hA1_51; w[1] = 16'hA2_52; w[2] = 16'hA3_53;
    a_rdy = 1'b1; b_rdy = 1'b0;
    in_vld = 1'b1; in_data = w[0];
    tick(acc);
    in_data = w[1];
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_w1_rdy: got %b want 1", in_rdy); end
    tick(acc);
    in_data = w[2];
    checks++;
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_full_rdy: got %b want 0", in_rdy); end
    tick(acc);
    checks++;
    if (in_rdy !== 1'b0 || got_a.size() != 2 || exp_a.size() != 2) begin
      errors++;
      $display("FAIL stall_a_drained: got in_rdy=%b a_out=%0d accepted=%0d want 0 2 2",
               in_rdy, got_a.size(), exp_a.size());
    end
    b_rdy = 1'b1;
    tick(acc);
    checks++;
    if (in_rdy !== 1'b1 || got_b.size() != 1) begin
      errors++;
      $display("FAIL stall_release: got in_rdy=%b b_out=%0d want 1 1", in_rdy, got_b.size());
    end
    tick(acc);
    checks++;
    if (!acc) begin errors++; $display("FAIL stall_w2_accept: got %b want 1", acc); end
    in_vld = 1'b0;
    for (int i = 0; i < 4; i++) tick(acc);
    checks++;
    if (got_a.size() != 3 || got_b.size() != 3) begin
      errors++;
      $display("FAIL stall_count: got a=%0d b=%0d want 3 3", got_a.size(), got_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL stall_a: got %h want %h", g, e); end
    end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL stall_b: got %h want %h", g, e); end
    end
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic test_toggle_rdy();
    bit acc;
    int seq = 0;
    for (int c = 0; c < 20; c++) begin
      a_rdy = (c % 2 == 0); b_rdy = a_rdy;
      in_vld = 1'b1;
      in_data = {8'(8'h80 + seq), 8'(seq)};
      tick(acc);
      if (acc) seq++;
      checks++;
      if (exp_a.size() - got_a.size() > 2 || exp_b.size() - got_b.size() > 2) begin
        errors++;
        $display("FAIL toggle_occupancy cycle %0d: got a=%0d b=%0d want <=2", c,
                 exp_a.size() - got_a.size(), exp_b.size() - got_b.size());
      end
    end
    in_vld = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick(acc);
    checks++;
    if (got_a.size() != seq || got_b.size() != seq || seq < 8) begin
      errors++;
      $display("FAIL toggle_count: got a=%0d b=%0d want %0d (>=8)", got_a.size(), got_b.size(), seq);
    end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_a.pop_front(); e = exp_a.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL toggle_a: got %h want %h", g, e); end
    end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_b.pop_front(); e = exp_b.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL toggle_b: got %h want %h", g, e); end
    end
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic test_mid_reset();
    bit acc;
    a_rdy = 1'b0; b_rdy = 1'b0;
    in_vld = 1'b1; in_data = 16'hEE_11; tick(acc);
    in_data = 16'hDD_22; tick(acc);
    in_vld = 1'b0;
    checks++;
    if (in_rdy !== 1'b0 || exp_a.size() != 2) begin
      errors++;
      $display("FAIL midrst_full: got in_rdy=%b accepted=%0d want 0 2", in_rdy, exp_a.size());
    end
    rst = 1'b0;
    tick(acc);
    rst = 1'b1;
    exp_a.delete(); exp_b.delete();
    #1;
    checks++;
    if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
      errors++;
      $display("FAIL midrst_vld: got a=%b b=%b want 0 0", a_vld, b_vld);
    end
`ifdef STREAM_SPLITTER_COUNTERS_EN
    checks++;
    if (in_cnt !== 16'd0 || a_cnt !== 16'd0 || b_cnt !== 16'd0 || skew !== 2'd0) begin
      errors++;
      $display("FAIL midrst_counters: got %0d %0d %0d %0d want 0 0 0 0", in_cnt, a_cnt, b_cnt, skew);
    end
`endif
    a_rdy = 1'b1; b_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick(acc);
    checks++;
    if (got_a.size() != 0 || got_b.size() != 0) begin
      errors++;
      $display("FAIL midrst_stale: got a_out=%0d b_out=%0d want 0 0", got_a.size(), got_b.size());
    end
    got_a.delete(); got_b.delete();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_b_stall();
    test_toggle_rdy();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
